// File: rtl/postfix_evaluator.sv
// Stack-machine evaluator for postfix code streams. Operand decoding and
// arithmetic are delegated to external units through strobe handshakes.
module postfix_evaluator #(
  parameter int DATA_WIDTH      = 32,
  parameter int CODE_WIDTH      = 8,
  parameter int STACK_DEPTH     = 8,
  parameter int PROG_ADDR_WIDTH = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [PROG_ADDR_WIDTH-1:0] start_addr,
  output logic                       busy,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic [CODE_WIDTH-1:0]      prog_data,
  output logic                       operand_req,
  output logic [CODE_WIDTH-1:0]      operand_code,
  input  logic                       operand_valid,
  input  logic [DATA_WIDTH-1:0]      operand_data,
  output logic                       alu_start,
  output logic [2:0]                 alu_op,
  output logic [DATA_WIDTH-1:0]      operand_a,
  output logic [DATA_WIDTH-1:0]      operand_b,
  input  logic                       alu_done,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  output logic [DATA_WIDTH-1:0]      result,
  output logic                       result_valid,
  output logic                       error,
  output logic [1:0]                 error_code
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, OPERAND_WAIT, ALU_ISSUE, ALU_WAIT, DONE, FAULT
  } state_t;

  state_t                state;
  logic [SPW-1:0]        sp;
  logic [1:0]            fault_code;
  logic [DATA_WIDTH-1:0] stack [STACK_DEPTH];

  logic          is_end, is_op;
  logic [2:0]    opcode;
  logic [AW-1:0] idx_a, idx_b, idx_push;

  assign is_end   = &prog_data;
  assign is_op    = (prog_data[CODE_WIDTH-1 -: 2] == 2'b10);
  assign opcode   = prog_data[2:0];
  assign idx_a    = AW'(sp - SPW'(2));
  assign idx_b    = AW'(sp - SPW'(1));
  assign idx_push = AW'(sp);

  // Stack storage carries no reset; sp gates every read so stale data never escapes.
  always_ff @(posedge clock) begin
    if (state == OPERAND_WAIT && operand_valid)
      stack[idx_push] <= operand_data;
    else if (state == ALU_WAIT && alu_done)
      stack[idx_a] <= alu_result;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sp           <= '0;
      prog_addr    <= '0;
      busy         <= 1'b0;
      operand_req  <= 1'b0;
      operand_code <= '0;
      alu_start    <= 1'b0;
      alu_op       <= '0;
      operand_a    <= '0;
      operand_b    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      error_code   <= '0;
      fault_code   <= '0;
    end else begin
      operand_req  <= 1'b0;
      alu_start    <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      case (state)
        IDLE: if (start) begin
          prog_addr  <= start_addr;
          sp         <= '0;
          error_code <= '0;
          busy       <= 1'b1;
          state      <= FETCH;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          prog_addr <= prog_addr + PROG_ADDR_WIDTH'(1);
          if (is_end) begin
            if (sp == SPW'(1)) state <= DONE;
            else begin fault_code <= 2'd0; state <= FAULT; end
          end else if (is_op) begin
            // Bad opcode takes precedence over stack underflow.
            if (opcode > OP_SUB) begin
              fault_code <= 2'd3; state <= FAULT;
            end else if (sp < SPW'(2)) begin
              fault_code <= 2'd2; state <= FAULT;
            end else begin
              alu_op    <= opcode;
              operand_a <= stack[idx_a];
              operand_b <= (opcode == OP_SUB) ? (stack[idx_b] ^ MSB_MASK) : stack[idx_b];
              alu_start <= 1'b1;
              state     <= ALU_ISSUE;
            end
          end else if (sp == SPW'(STACK_DEPTH)) begin
            fault_code <= 2'd1; state <= FAULT;
          end else begin
            operand_req  <= 1'b1;
            operand_code <= prog_data;
            state        <= OPERAND_WAIT;
          end
        end
        OPERAND_WAIT: if (operand_valid) begin
          sp    <= sp + SPW'(1);
          state <= FETCH;
        end
        ALU_ISSUE: state <= ALU_WAIT;
        ALU_WAIT: if (alu_done) begin
          sp    <= sp - SPW'(1);
          state <= FETCH;
        end
        DONE: begin
          result       <= stack[0];
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        FAULT: begin
          error      <= 1'b1;
          error_code <= fault_code;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
